// File: rtl/aes192_round_engine.sv
// aes192_round_engine: iterative AES-192 encryption, one round per clock over a pre-expanded key
module aes192_round_engine #(
  parameter int NR = 12,
  parameter int KW = 128 * (NR + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [127:0]    plaintext,
  input  logic [KW-1:0]   exp_key,
  output logic            busy,
  output logic            done,
  output logic [127:0]    ciphertext
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (b^254, zero maps to zero) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    logic [7:0] v;
    s = b;
    v = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      v = gmul(v, s);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // byte i sits in row i%4, column i/4; row r takes its byte from column (c+r)%4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[127-8*(i%4 + 4*((i/4 + i%4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  fsm_t         r_fsm;
  fsm_t         w_fsm_nxt;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic         r_busy;
  logic         r_done;
  logic [127:0] r_ct;
  logic [127:0] w_rks [NR+1];
  logic [3:0]   w_rsel;
  logic [127:0] w_rk;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic         w_valid;
  logic         w_last;
  logic         w_start;

  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign w_rks[g] = exp_key[KW-1-128*g -: 128];
  end

  assign w_valid = (r_round >= 4'd1) && (r_round <= 4'(NR));
  assign w_last  = (r_fsm == RUN) && w_valid && (r_round == 4'(NR));
  assign w_start = (r_fsm == IDLE) && start;
  assign w_rsel  = w_valid ? r_round : 4'd0;
  assign w_rk    = w_rks[w_rsel];
  assign w_sr    = shift_rows(sub_bytes(r_state));
  assign w_mc    = mix_columns(w_sr);

  assign busy       = r_busy;
  assign done       = r_done;
  assign ciphertext = r_ct;

  // next state: leave IDLE on start, leave RUN after the final round or on a corrupt round count
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_fsm_nxt = (r_fsm == IDLE) ? (start ? RUN : IDLE) : ((w_last || !w_valid) ? IDLE : RUN);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else r_fsm <= w_fsm_nxt;
  end

  // round datapath: initial whitening on start, full rounds 1..NR-1, final round without MixColumns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_round <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ct    <= '0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_state <= plaintext ^ w_rks[0];
        r_round <= 4'd1;
        r_busy  <= 1'b1;
      end else if (r_fsm == RUN) begin
        if (w_last) begin
          r_ct    <= w_sr ^ w_rk;
          r_round <= '0;
          r_busy  <= 1'b0;
        end else if (!w_valid) begin
          r_round <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_state <= w_mc ^ w_rk;
          r_round <= r_round + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes192_round_engine.sv
// tb_aes192_round_engine: directed and random checks of the AES-192 round engine against a byte-level model
module tb_aes192_round_engine;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [127:0]   plaintext = '0;
  logic [1663:0]  exp_key = '0;
  logic           busy;
  logic           done;
  logic [127:0]   ciphertext;

  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] sb [256];

  localparam logic [191:0] C2_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C2_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] Z_CT   = 128'haae06992acbf52a3e8f4a96ec9300bd7;

  aes192_round_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext), .exp_key(exp_key),
    .busy(busy), .done(done), .ciphertext(ciphertext)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [15:0] d;
    d = {v, v};
    return d[15-s -: 8];
  endfunction

  // S-box built by walking the multiplicative group with generator 3 and its inverse in lockstep
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [1663:0] expand(input logic [191:0] k);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1663:0] r;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int i = 0; i < 52; i++) r[1663-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [1663:0] ek, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] m [4][4];
    logic [127:0] o;
    m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
          '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ek[1663-8*i -: 8];
    for (int r = 1; r <= 12; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int i = 0; i < 16; i++) s[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (r < 12) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) begin
            t[4*c+row] = 8'h00;
            for (int j = 0; j < 4; j++) t[4*c+row] = t[4*c+row] ^ gf_mul(m[row][j], s[4*c+j]);
          end
        end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[1663-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input string tag, input logic [1663:0] ek, input logic [127:0] pt,
                           input logic [127:0] exp_ct);
    int n, nb;
    exp_key = ek;
    plaintext = pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    plaintext = rand128();
    n = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      nb += busy ? 1 : 0;
    end
    chk({tag, "_latency"}, 128'(n), 128'(12));
    chk({tag, "_busy_cycles"}, 128'(nb), 128'(12));
    chk({tag, "_ct"}, ciphertext, exp_ct);
    tick();
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    logic [1663:0] k_c2, k_z, ek;
    logic [127:0] pt, held;
    int n, nd;
    init_sbox();
    k_c2 = expand(C2_KEY);
    k_z = expand(192'h0);

    repeat (3) tick();
    chk("por_busy", 128'(busy), 128'(0));
    chk("por_done", 128'(done), 128'(0));
    chk("por_ct", ciphertext, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 128'(busy), 128'(0));

    run_block("c2", k_c2, C2_PT, C2_CT);
    run_block("zero", k_z, 128'h0, Z_CT);
    for (int i = 0; i < 4; i++) begin
      ek = expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      pt = rand128();
      run_block("rand", ek, pt, encrypt(ek, pt));
    end

    exp_key = k_c2;
    plaintext = C2_PT;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    plaintext = 128'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        nd++;
        chk("busy_start_ct", ciphertext, C2_CT);
      end
      tick();
    end
    chk("busy_start_dones", 128'(nd), 128'(1));

    exp_key = k_c2;
    plaintext = C2_PT;
    start = 1'b1;
    tick();
    plaintext = 128'h0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_first_latency", 128'(n), 128'(12));
    chk("b2b_first_ct", ciphertext, C2_CT);
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_gap", 128'(n), 128'(13));
    chk("b2b_second_ct", ciphertext, encrypt(k_c2, 128'h0));

    held = ciphertext;
    for (int i = 0; i < 50; i++) begin
      plaintext = rand128();
      tick();
      chk("hold_ct", ciphertext, held);
    end

    exp_key = k_c2;
    plaintext = C2_PT;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_ct", ciphertext, 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nd += done ? 1 : 0;
    end
    chk("rst_no_done", 128'(nd), 128'(0));
    run_block("after_rst", k_c2, C2_PT, C2_CT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
